// File: rtl/parallel_to_serial.sv
// Byte-to-bit serializer: sends a comma preamble after reset, then one symbol per
// 8 clocks, MSB first, taking an upstream byte (or an idle comma) at each boundary.
module parallel_to_serial #(
    parameter logic [7:0] IDLE_SYM    = 8'hBC,
    parameter int         INIT_COMMAS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       take_out,
    output logic       data_out,
    output logic       sym_start,
    output logic       sync_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] LAST_COMMA = 4'(INIT_COMMAS - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_sh;
    logic [7:0] w_sh_next;
    logic [3:0] r_comma_cnt;
    logic [3:0] w_comma_cnt_next;
    logic       r_data_out;
    logic       r_sym_start;
    logic       r_sync_done;
    logic       w_sync_done_next;
    logic       w_boundary;
    logic       w_take;

    assign w_boundary = (r_bit_cnt == 3'd7);
    // The last preamble boundary already accepts data, which is what makes the
    // reset-loaded symbol count as comma 0.
    assign w_take     = w_boundary && ((r_state == ST_RUN) || (r_comma_cnt == LAST_COMMA));

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next     = r_state;
        w_comma_cnt_next = r_comma_cnt;
        w_sync_done_next = r_sync_done;
        w_sh_next        = {r_sh[6:0], 1'b0};
        if (w_take) begin
            w_sh_next        = valid_in ? data_in : IDLE_SYM;
            w_state_next     = ST_RUN;
            w_sync_done_next = 1'b1;
        end else if (w_boundary) begin
            w_sh_next        = IDLE_SYM;
            w_comma_cnt_next = r_comma_cnt + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_bit_cnt   <= 3'd0;
            r_sh        <= IDLE_SYM;
            r_comma_cnt <= 4'd0;
            r_data_out  <= 1'b0;
            r_sym_start <= 1'b0;
            r_sync_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= r_bit_cnt + 3'd1;
            r_sh        <= w_sh_next;
            r_comma_cnt <= w_comma_cnt_next;
            r_data_out  <= r_sh[7];
            r_sym_start <= (r_bit_cnt == 3'd0);
            r_sync_done <= w_sync_done_next;
        end
    end

    assign take_out  = w_take && !reset;
    assign data_out  = r_data_out;
    assign sym_start = r_sym_start;
    assign sync_done = r_sync_done;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: two instances (INIT_COMMAS=4 and 1) share stimulus and
// are checked against a symbol-list model built from the edge count since reset release.
module tb_parallel_to_serial;

    localparam logic [7:0] IDLE = 8'hBC;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic [1:0] take_out;
    logic [1:0] data_out;
    logic [1:0] sym_start;
    logic [1:0] sync_done;

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         e      = 0;
    logic [7:0] sym    [0:1][0:255];
    int         ic_of  [0:1] = '{4, 1};

    always #5 clk = ~clk;

    parallel_to_serial #(.IDLE_SYM(IDLE), .INIT_COMMAS(4)) u_dut4 (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .take_out (take_out[0]),
        .data_out (data_out[0]),
        .sym_start(sym_start[0]),
        .sync_done(sync_done[0])
    );

    parallel_to_serial #(.IDLE_SYM(IDLE), .INIT_COMMAS(1)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .take_out (take_out[1]),
        .data_out (data_out[1]),
        .sym_start(sym_start[1]),
        .sync_done(sync_done[1])
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d after reset)", tag, obs, exp, e);
        end
    endtask

    // Every symbol slot starts as a comma; slots at take boundaries are overwritten.
    task automatic model_reset();
        e = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 256; j++)
                sym[i][j] = IDLE;
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset take_out ic=%0d", ic_of[i]), 8'(take_out[i]), 8'h00);
            check($sformatf("reset data_out ic=%0d", ic_of[i]), 8'(data_out[i]), 8'h00);
            check($sformatf("reset sym_start ic=%0d", ic_of[i]), 8'(sym_start[i]), 8'h00);
            check($sformatf("reset sync_done ic=%0d", ic_of[i]), 8'(sync_done[i]), 8'h00);
        end
    endtask

    // Entered and left 1 time unit after a rising edge; reset is released there.
    task automatic apply_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        #1;
        check_reset_state();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: glitch values first, final values from the falling edge up to the edge.
    task automatic step(input logic gv, input logic [7:0] gd, input logic v, input logic [7:0] d);
        logic exp_take;
        int   j;
        int   b;
        valid_in = gv;
        data_in  = gd;
        @(negedge clk);
        valid_in = v;
        data_in  = d;
        for (int i = 0; i < 2; i++) begin
            exp_take = (((e + 1) % 8) == 0) && ((e + 1) >= 8 * ic_of[i]);
            check($sformatf("take_out ic=%0d", ic_of[i]), 8'(take_out[i]), 8'(exp_take));
            if (exp_take)
                sym[i][(e + 1) / 8] = v ? d : IDLE;
        end
        @(posedge clk);
        #1;
        e++;
        j = (e - 1) / 8;
        b = (e - 1) % 8;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("data_out ic=%0d sym %0d bit %0d", ic_of[i], j, 7 - b),
                  8'(data_out[i]), 8'(sym[i][j][7 - b]));
            check($sformatf("sym_start ic=%0d", ic_of[i]), 8'(sym_start[i]), 8'(b == 0));
            check($sformatf("sync_done ic=%0d", ic_of[i]), 8'(sync_done[i]),
                  8'(e >= 8 * ic_of[i]));
        end
    endtask

    // Eight clocks ending on a boundary; (v,d) is what is present at that boundary.
    task automatic run_symbol(input logic v, input logic [7:0] d, input bit glitch);
        for (int k = 0; k < 8; k++) begin
            if (!glitch)
                step(v, d, v, d);
            else if (k == 7)
                step(1'($urandom_range(0, 1)), 8'($urandom), v, d);
            else
                step(1'($urandom_range(0, 1)), 8'($urandom),
                     1'($urandom_range(0, 1)), 8'($urandom));
        end
    endtask

    initial begin
        logic       rv;
        logic [7:0] rd;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        @(posedge clk);
        #1;

        // Idle after reset: commas only, first take at clock 32 (clock 8 for one comma).
        apply_reset();
        repeat (5) run_symbol(1'b0, 8'h00, 1'b0);

        // Data held from release is blocked by the preamble.
        apply_reset();
        repeat (6) run_symbol(1'b1, 8'h11, 1'b0);

        // Alternating valid / idle / valid in RUN, plus one symbol to shift the last out.
        apply_reset();
        repeat (4) run_symbol(1'b0, 8'h00, 1'b0);
        run_symbol(1'b1, 8'h13, 1'b0);
        run_symbol(1'b0, 8'h00, 1'b0);
        run_symbol(1'b1, 8'hFD, 1'b0);
        run_symbol(1'b0, 8'h00, 1'b0);

        // Reset three bits into an 8'hFF symbol, then the preamble must repeat.
        run_symbol(1'b1, 8'hFF, 1'b0);
        repeat (3) step(1'b1, 8'hFF, 1'b1, 8'hFF);
        apply_reset();
        repeat (6) run_symbol(1'b1, 8'hFF, 1'b0);

        // Random bytes with glitching between boundaries; some valid bytes equal the comma.
        repeat (30) begin
            rv = 1'($urandom_range(0, 1));
            rd = ($urandom_range(0, 3) == 0) ? IDLE : 8'($urandom);
            run_symbol(rv, rd, 1'b1);
        end
        run_symbol(1'b0, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
